chunked_add_sub: RTL and testbench
==================================

// Module: chunked_add_sub
// PURPOSE
//  Multi-cycle, parametrised adder/subtractor built on the full-adder carry chain.
//  Adds or subtracts two WIDTH-bit operands CHUNK bits per cycle, LSB chunk first,
//  with a start/ready/done handshake.
//  Used by the processor execute stage for wide arithmetic without a long ripple path.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be >= 2
//  CHUNK   4  bits processed per cycle; WIDTH % CHUNK == 0 (elaboration error otherwise)
// PORTS
//  clk    in   1      rising-edge clock, single clock domain
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      request; sampled only when ready=1
//  sub    in   1      0 = a+b+cin, 1 = a-b-cin (cin acts as borrow-in)
//  a      in   WIDTH  operand A, captured on accepted start
//  b      in   WIDTH  operand B, captured on accepted start
//  cin    in   1      carry-in (add) / borrow-in (sub), captured on accepted start
//  ready  out  1      1 in IDLE only; start is accepted when start&ready
//  done   out  1      1-cycle pulse: result outputs valid
//  sum    out  WIDTH  result
//  cout   out  1      carry-out (add) / borrow-out = ~carry (sub)
//  ovf    out  1      two's-complement overflow = carry into MSB ^ carry out of MSB
//  zero   out  1      sum == 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, ready=1, done=0, sum=0, cout=0, ovf=0, zero=0.
//    Internal operand, carry and chunk counter are cleared.
//  - Let N = WIDTH/CHUNK.
//  - States:
//    IDLE -> RUN on start&ready.
//    RUN -> DONE after chunk N-1 is processed.
//    DONE -> IDLE unconditionally after 1 cycle.
//  - On accept at edge T:
//    latch a; latch b, inverted when sub=1.
//    Initial carry = cin when sub=0, ~cin when sub=1.
//    Chunk counter = 0.
//  - RUN: at each edge, chunk k = bits [k*CHUNK +: CHUNK] is added with the carry
//    register. The CHUNK-bit result is stored and the carry register updated.
//    The counter increments.
//  - Edge T+N: state=DONE, done=1. sum/cout/ovf/zero are updated from the final
//    chunk and carries.
//  - Edge T+N+1: state=IDLE, done=0, ready=1.
//  - Latency: start accept to done = N cycles. Throughput: one op per N+2 cycles.
//  - sum, cout, ovf and zero change only at the DONE-entry edge. They hold their
//    value through the following IDLE and RUN until the next DONE entry.
//  - start while RUN/DONE is ignored: no queuing. Changes to a/b/cin/sub after
//    accept have no effect.
//  - Arithmetic is modulo 2^WIDTH. ovf uses the carry into bit WIDTH-1 and the carry
//    out of bit WIDTH-1, on the effective (possibly inverted) b.
//  - CHUNK == WIDTH: N=1, so RUN lasts 1 cycle.
//  - Reset asserted mid-RUN/DONE: operation is aborted. No done pulse; ready=1 and
//    outputs=0 immediately.
// TESTING (WIDTH=16, CHUNK=4 unless noted)
//  - add 0x00FF+0x0001, cin=0
//    -> done exactly 4 cycles after accept.
//    -> sum=0x0100, cout=0, ovf=0, zero=0.
//  - add 0x7FFF+0x0001
//    -> sum=0x8000, ovf=1, cout=0.
//    add 0xFFFF+0x0000, cin=1
//    -> sum=0x0000, cout=1, zero=1, ovf=0.
//  - sub 0x0005-0x0007, cin=0
//    -> sum=0xFFFE, cout(borrow)=1, ovf=0.
//    sub 0x1234-0x1234
//    -> sum=0, zero=1, cout=0.
//    sub 0x8000-0x0001
//    -> 0x7FFF, ovf=1.
//  - start held high throughout, a/b changed during RUN
//    -> first op result unaffected; ready=0 in RUN/DONE.
//    -> next accept exactly at the IDLE cycle; done spacing = 6 cycles.
//  - rst_n pulled low on 2nd RUN cycle
//    -> no done; ready=1, sum=0 asynchronously.
//    -> a following op completes correctly.
//  - Random 10k ops vs behavioural model: (WIDTH,CHUNK) = (16,4), (8,1), (8,8), (32,16).
//    -> all sum/cout/ovf/zero match.

Source files
------------

// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per cycle, LSB chunk first, on a start/ready/done handshake.
// Latency: WIDTH/CHUNK cycles from accepted start to the done pulse; one op every WIDTH/CHUNK+2 cycles.
// Backpressure: ready is high only in IDLE; start outside IDLE is dropped, no queuing.
module chunked_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_add_sub: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_nxt;
    logic             carry_q;
    logic             sub_q;
    logic [CW-1:0]    cnt;
    logic [CHUNK:0]   chunk_sum;
    logic             last;
    logic             msb_cin;

    // Operands shift right each RUN cycle so the active chunk is always in the low bits.
    assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    assign last      = (cnt == CW'(N - 1));
    // Carry into the MSB, recovered from the final chunk's top bits.
    assign msb_cin   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];

    generate
        if (N == 1) begin : g_single
            assign res_nxt = chunk_sum[CHUNK-1:0];
        end else begin : g_multi
            assign res_nxt = {chunk_sum[CHUNK-1:0], res_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= cin ^ sub;
                        sub_q   <= sub;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= chunk_sum[CHUNK];
                    res_q   <= res_nxt;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        sum  <= res_nxt;
                        cout <= chunk_sum[CHUNK] ^ sub_q;
                        ovf  <= msb_cin ^ chunk_sum[CHUNK];
                        zero <= (res_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: (16,4) main instance checked every cycle against a signed/unsigned
// arithmetic model, plus a (8,8) instance covering the single-chunk case.
`timescale 1ns/1ps
module tb_chunked_add_sub;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [15:0] sum;
    logic        ready, done, cout, ovf, zero;

    logic        start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
    logic [7:0]  a2 = '0, b2 = '0;
    logic [7:0]  sum2;
    logic        ready2, done2, cout2, ovf2, zero2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .ready(ready), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    chunked_add_sub #(.WIDTH(8), .CHUNK(8)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
        .ready(ready2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer arithmetic; overflow means the signed result leaves the w-bit range.
    function automatic res_t model(int w, logic [63:0] x, logic [63:0] y, logic ci, logic sb);
        longint ux, uy, sx, sy, u, s, lim;
        res_t   r;
        ux  = longint'(x);
        uy  = longint'(y);
        lim = longint'(1) << (w - 1);
        sx  = x[w-1] ? ux - 2 * lim : ux;
        sy  = y[w-1] ? uy - 2 * lim : uy;
        if (!sb) begin
            u      = ux + uy + longint'(ci);
            s      = sx + sy + longint'(ci);
            r.cout = (u >= 2 * lim);
        end else begin
            u      = ux - uy - longint'(ci);
            s      = sx - sy - longint'(ci);
            r.cout = (u < 0);
        end
        r.sum  = 64'(u & (2 * lim - 1));
        r.ovf  = (s >= lim) || (s < -lim);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    function automatic res_t mk(logic [63:0] s, logic c, logic v, logic z);
        res_t r;
        r.sum = s; r.cout = c; r.ovf = v; r.zero = z;
        return r;
    endfunction

    function automatic res_t dut_res();
        return mk({48'd0, sum}, cout, ovf, zero);
    endfunction

    function automatic res_t dut2_res();
        return mk({56'd0, sum2}, cout2, ovf2, zero2);
    endfunction

    task automatic check(string name, res_t got, res_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                     name, got.sum, got.cout, got.ovf, got.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Per-cycle compare: results at done, hold otherwise, ready vs ops in flight, latency.
    res_t exp_q[$];
    int   acc_q[$];
    res_t held = '0;

    always @(negedge clk) begin
        res_t e;
        int   t;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            held = '0;
            check_int("reset_ready", int'(ready), 1);
            check_int("reset_done", int'(done), 0);
            check("reset_outputs", dut_res(), '0);
        end else begin
            check_int("ready", int'(ready), int'(exp_q.size() == 0));
            if (done) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_done: got done=1 at cycle %0d, expected no op in flight", cyc);
                end else begin
                    e = exp_q.pop_front();
                    t = acc_q.pop_front();
                    check("result", dut_res(), e);
                    check_int("latency", cyc - t, 4);
                    held = e;
                end
            end else begin
                check("hold", dut_res(), held);
            end
            if (start && ready) begin
                exp_q.push_back(model(16, {48'd0, a}, {48'd0, b}, cin, sub));
                acc_q.push_back(cyc + 1);
            end
        end
    end

    task automatic go(logic [15:0] x, logic [15:0] y, logic ci, logic sb);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        a = x; b = y; cin = ci; sub = sb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_int("done_seen", int'(seen), 1);
    endtask

    task automatic run_op(string name, logic [15:0] x, logic [15:0] y, logic ci, logic sb, res_t exp);
        go(x, y, ci, sb);
        check(name, dut_res(), exp);
    endtask

    initial begin
        int   nd, prev;
        res_t e2;

        check("pin_add", model(16, 64'h00FF, 64'h0001, 1'b0, 1'b0), mk(64'h0100, 0, 0, 0));
        check("pin_add_ovf", model(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0), mk(64'h8000, 0, 1, 0));
        check("pin_add_wrap", model(16, 64'hFFFF, 64'h0000, 1'b1, 1'b0), mk(64'h0000, 1, 0, 1));
        check("pin_sub_borrow", model(16, 64'h0005, 64'h0007, 1'b0, 1'b1), mk(64'hFFFE, 1, 0, 0));
        check("pin_sub_zero", model(16, 64'h1234, 64'h1234, 1'b0, 1'b1), mk(64'h0000, 0, 0, 1));
        check("pin_sub_ovf", model(16, 64'h8000, 64'h0001, 1'b0, 1'b1), mk(64'h7FFF, 0, 1, 0));

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", dut_res(), '0);
        check_int("post_reset_ready", int'(ready), 1);

        run_op("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, mk(64'h0100, 0, 0, 0));
        run_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(64'h8000, 0, 1, 0));
        run_op("add_ffff_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(64'h0000, 1, 0, 1));
        run_op("sub_5_7",       16'h0005, 16'h0007, 1'b0, 1'b1, mk(64'hFFFE, 1, 0, 0));
        run_op("sub_1234_1234", 16'h1234, 16'h1234, 1'b0, 1'b1, mk(64'h0000, 0, 0, 1));
        run_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b0, 1'b1, mk(64'h7FFF, 0, 1, 0));
        run_op("sub_borrow_in", 16'h0010, 16'h0003, 1'b1, 1'b1, mk(64'h000C, 0, 0, 0));

        // start held high while operands keep changing
        nd = 0;
        prev = 0;
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (done) begin
                if (nd == 0) check("held_first", dut_res(), mk(64'h3333, 0, 0, 0));
                else check_int("done_spacing", cyc - prev, 6);
                prev = cyc;
                nd++;
            end
            @(posedge clk); #1;
            a = a + 16'h0101;
            b = b + 16'h0011;
        end
        start = 1'b0;
        check_int("held_done_count", int'(nd >= 3), 1);
        repeat (8) @(posedge clk);

        // reset during the second RUN cycle aborts the op
        @(posedge clk); #1;
        a = 16'h4000; b = 16'h0123; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_int("abort_ready", int'(ready), 1);
        check_int("abort_done", int'(done), 0);
        check("abort_outputs", dut_res(), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        run_op("after_abort", 16'h1234, 16'h4321, 1'b1, 1'b0, mk(64'h5556, 0, 0, 0));

        for (int i = 0; i < 150; i++) begin
            go(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        go(16'h8000, 16'h8000, 1'b0, 1'b0);
        go(16'h7FFF, 16'hFFFF, 1'b1, 1'b1);

        // single-chunk instance: RUN lasts one cycle
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            a2 = 8'($urandom); b2 = 8'($urandom); cin2 = 1'($urandom); sub2 = 1'($urandom);
            if (i == 0) begin a2 = 8'h7F; b2 = 8'h01; cin2 = 1'b0; sub2 = 1'b0; end
            e2 = model(8, {56'd0, a2}, {56'd0, b2}, cin2, sub2);
            if (i == 0) check("n1_pin", e2, mk(64'h80, 0, 1, 0));
            check_int("n1_ready", int'(ready2), 1);
            start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            @(negedge clk);
            check_int("n1_run", int'(done2), 0);
            @(negedge clk);
            check_int("n1_done", int'(done2), 1);
            check("n1_result", dut2_res(), e2);
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
